// File: rtl/audplay_pkg.sv
// Shared constants for the audio playback/acquisition blocks:
// FSM encodings, frame geometry and the serial bit-slot helper.
package audplay_pkg;

    localparam logic [1:0] AUDPLAY_IDLE  = 2'd0;
    localparam logic [1:0] AUDPLAY_LEFT  = 2'd1;
    localparam logic [1:0] AUDPLAY_RIGHT = 2'd2;

    localparam int AUD_HALF_TICKS = 64;
    localparam int AUD_SAMPLE_W   = 16;

    // Bit on sd for a given count within a half: slots 2..33, two ticks per bit, MSB first
    function automatic logic sd_bit(input logic [5:0] c,
                                    input logic [AUD_SAMPLE_W-1:0] s);
        logic [3:0] k;
        if (c < 6'd2 || c > 6'd33) begin
            return 1'b0;
        end
        k = 4'((c - 6'd2) >> 1);
        return s[~k];
    endfunction

endpackage

// File: rtl/audplay_fifo.sv
// Synchronous sample FIFO with wrap-bit pointers; occupancy is the
// pointer difference, so full and empty are both derived from it.
module audplay_fifo
    import audplay_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = AUD_SAMPLE_W
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_push;
    logic         do_pop;

    assign level   = wptr - rptr;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/audplay_tx.sv
// Mono I2S-style playback master: tick divider, frame FSM, sample
// shifter and underrun accounting in front of the sample FIFO.
module audplay_tx
    import audplay_pkg::*;
#(
    parameter int    PRIMARY_DIV = 26,
    parameter int    FIFO_DEPTH  = 8,
    parameter string RIGHT_MODE  = "dup"
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          en,
    input  logic                          s_vld,
    input  logic [15:0]                   s_data,
    output logic                          s_rdy,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          underrun,
    output logic [15:0]                   underrun_cnt,
    output logic                          sck,
    output logic                          ws,
    output logic                          lrs,
    output logic                          sd
);

    localparam int  DW    = (PRIMARY_DIV > 1) ? $clog2(PRIMARY_DIV) : 1;
    localparam bit  RZERO = (RIGHT_MODE == "zero");
    localparam logic [5:0] LAST = 6'(AUD_HALF_TICKS - 1);

    logic [DW-1:0]            div;
    logic                     tick;
    logic [1:0]               state;
    logic [1:0]               state_n;
    logic [5:0]               count;
    logic [5:0]               count_n;
    logic                     enter_left;
    logic [AUD_SAMPLE_W-1:0]  shreg;
    logic [AUD_SAMPLE_W-1:0]  shreg_n;
    logic                     sd_n;
    logic                     f_full;
    logic                     f_empty;
    logic                     f_pop;
    logic                     ur_ev;
    logic [AUD_SAMPLE_W-1:0]  f_head;

    assign tick = (div == '0);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            div <= '0;
        end else if (div == DW'(PRIMARY_DIV - 1)) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    always_comb begin
        state_n    = state;
        count_n    = count;
        enter_left = 1'b0;
        case (state)
            AUDPLAY_IDLE: begin
                if (!en) begin
                    count_n = '0;
                end else if (count == LAST) begin
                    state_n    = AUDPLAY_LEFT;
                    count_n    = '0;
                    enter_left = 1'b1;
                end else begin
                    count_n = count + 1'b1;
                end
            end
            AUDPLAY_LEFT: begin
                if (count == LAST) begin
                    state_n = AUDPLAY_RIGHT;
                    count_n = '0;
                end else begin
                    count_n = count + 1'b1;
                end
            end
            AUDPLAY_RIGHT: begin
                if (count == LAST) begin
                    count_n = '0;
                    if (en) begin
                        state_n    = AUDPLAY_LEFT;
                        enter_left = 1'b1;
                    end else begin
                        state_n = AUDPLAY_IDLE;
                    end
                end else begin
                    count_n = count + 1'b1;
                end
            end
            default: begin
                state_n = AUDPLAY_IDLE;
                count_n = '0;
            end
        endcase
    end

    assign f_pop = tick & enter_left & ~f_empty;
    assign ur_ev = tick & enter_left & f_empty;

    // An empty FIFO at frame start plays a silent frame
    always_comb begin
        shreg_n = shreg;
        if (enter_left) begin
            shreg_n = f_empty ? '0 : f_head;
        end
        sd_n = 1'b0;
        case (state_n)
            AUDPLAY_LEFT:  sd_n = sd_bit(count_n, shreg_n);
            AUDPLAY_RIGHT: sd_n = RZERO ? 1'b0 : sd_bit(count_n, shreg_n);
            default:       sd_n = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= AUDPLAY_IDLE;
            count <= '0;
            shreg <= '0;
            sd    <= 1'b0;
        end else if (tick) begin
            state <= state_n;
            count <= count_n;
            shreg <= shreg_n;
            sd    <= sd_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            underrun <= ur_ev;
            if (ur_ev && underrun_cnt != 16'hFFFF) begin
                underrun_cnt <= underrun_cnt + 1'b1;
            end
        end
    end

    audplay_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (AUD_SAMPLE_W)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (s_vld),
        .pop   (f_pop),
        .wdata (s_data),
        .rdata (f_head),
        .full  (f_full),
        .empty (f_empty),
        .level (level)
    );

    assign s_rdy = ~f_full;
    assign sck   = (state == AUDPLAY_IDLE) | count[0];
    assign ws    = (state != AUDPLAY_LEFT);
    assign lrs   = 1'b0;

endmodule

// File: tb/tb_audplay_tx.sv
// Bench for audplay_tx: a DAC model captures left/right words on sck rise
// and per-scenario tasks compare them against a queue of pushed samples.
module tb_audplay_tx;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en;
    logic        s_vld;
    logic [15:0] s_data;
    logic        s_rdy;
    logic [3:0]  level;
    logic        underrun;
    logic [15:0] underrun_cnt;
    logic        sck;
    logic        ws;
    logic        lrs;
    logic        sd;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];
    logic [15:0] lq[$];
    logic [15:0] rq[$];
    int          ur_seen = 0;
    logic [15:0] exp_cnt = 16'h0;

    always #5 clk = ~clk;

    audplay_tx #(
        .PRIMARY_DIV (4),
        .FIFO_DEPTH  (8),
        .RIGHT_MODE  ("dup")
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .en           (en),
        .s_vld        (s_vld),
        .s_data       (s_data),
        .s_rdy        (s_rdy),
        .level        (level),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt),
        .sck          (sck),
        .ws           (ws),
        .lrs          (lrs),
        .sd           (sd)
    );

    // DAC model: bit slots are the 2nd..17th sck rises of each half
    int          idx = 0;
    logic [15:0] word = 16'h0;
    logic        sck_p = 1'b1;
    logic        ws_p = 1'b1;

    always @(negedge clk) begin
        if (!rstn) begin
            idx   = 0;
            word  = 16'h0;
            sck_p = 1'b1;
            ws_p  = 1'b1;
        end else begin
            if (ws != ws_p) begin
                idx  = 0;
                word = 16'h0;
            end
            if (!sck_p && sck) begin
                idx++;
                if (idx >= 2 && idx <= 17) word = {word[14:0], sd};
                if (idx == 17) begin
                    if (ws) rq.push_back(word);
                    else    lq.push_back(word);
                end
            end
            sck_p = sck;
            ws_p  = ws;
            if (underrun) ur_seen++;
        end
    end

    task automatic wait_idle(input string name);
        int run = 0;
        int n = 0;
        while (run < 12 && n < 2000) begin
            @(negedge clk);
            n++;
            if (sck && ws) run++;
            else run = 0;
        end
        if (run < 12) begin
            errors++;
            $display("FAIL %s: idle not reached, run=%0d required 12", name, run);
        end
    endtask

    task automatic wait_ur(input string name);
        int n = 0;
        while (!underrun && n < 1500) begin
            @(negedge clk);
            n++;
        end
        if (!underrun) begin
            errors++;
            $display("FAIL %s: underrun pulse timeout", name);
        end
    endtask

    task automatic push1(input logic [15:0] d);
        s_vld  = 1'b1;
        s_data = d;
        @(negedge clk);
        s_vld  = 1'b0;
    endtask

    task automatic test_reset;
        rstn  = 1'b0;
        en    = 1'b0;
        s_vld = 1'b0;
        s_data = 16'h0;
        repeat (3) @(negedge clk);
        checks++;
        if ({sck, ws, sd, lrs, s_rdy, underrun} !== 6'b110010) begin
            errors++;
            $display("FAIL reset_pins: got %b required 110010",
                     {sck, ws, sd, lrs, s_rdy, underrun});
        end
        checks++;
        if (level !== 4'd0 || underrun_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_level: level=%0d cnt=%h required 0/0000", level, underrun_cnt);
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single;
        int n = 0;
        exp_q.push_back(16'hA5C3);
        push1(16'hA5C3);
        checks++;
        if (level !== 4'd1) begin
            errors++;
            $display("FAIL single_level: got %0d required 1", level);
        end
        ur_seen = 0;
        en = 1'b1;
        while (rq.size() < 1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ur_seen != 0) begin
            errors++;
            $display("FAIL single_underrun: got %0d pulses required 0", ur_seen);
        end
        en = 1'b0;
        wait_idle("single_idle");
        checks++;
        if (lq.size() != 1 || rq.size() != 1) begin
            errors++;
            $display("FAIL single_words: got l=%0d r=%0d required 1/1", lq.size(), rq.size());
        end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            checks++;
            if (lq[0] !== e || rq[0] !== e) begin
                errors++;
                $display("FAIL single_data: got l=%h r=%h required %h", lq[0], rq[0], e);
            end
        end
        exp_q.delete();
        lq.delete();
        rq.delete();
    endtask

    task automatic test_underrun;
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_ur("ur_wait");
            exp_cnt = exp_cnt + 16'h1;
            @(negedge clk);
            checks++;
            if (underrun !== 1'b0 || underrun_cnt !== exp_cnt) begin
                errors++;
                $display("FAIL ur_count: pulse=%b cnt=%h required 0/%h", underrun, underrun_cnt, exp_cnt);
            end
        end
        en = 1'b0;
        wait_idle("ur_idle");
        checks++;
        if (lq.size() != 3 || rq.size() != 3) begin
            errors++;
            $display("FAIL ur_frames: got l=%0d r=%0d required 3/3", lq.size(), rq.size());
        end
        while (lq.size() > 0) begin
            logic [15:0] g;
            g = lq.pop_front();
            checks++;
            if (g !== 16'h0) begin
                errors++;
                $display("FAIL ur_silent: got %h required 0000", g);
            end
        end
        rq.delete();
    endtask

    task automatic test_back_to_back;
        int mlevel = 0;
        int n = 0;
        logic [15:0] smp [9];
        smp[0] = 16'h8000;
        smp[1] = 16'h7FFF;
        smp[2] = 16'hFFFF;
        smp[3] = 16'h0001;
        for (int i = 4; i < 9; i++) smp[i] = 16'($urandom);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (s_rdy !== (mlevel < 8)) begin
                errors++;
                $display("FAIL b2b_rdy[%0d]: got %b required %b", i, s_rdy, mlevel < 8);
            end
            if (mlevel < 8) begin
                exp_q.push_back(smp[i]);
                mlevel++;
            end
            s_vld  = 1'b1;
            s_data = smp[i];
            @(negedge clk);
        end
        s_vld = 1'b0;
        checks++;
        if (level !== 4'(mlevel) || s_rdy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_full: level=%0d rdy=%b required %0d/0", level, s_rdy, mlevel);
        end
        exp_q.push_back(16'h0);
        ur_seen = 0;
        en = 1'b1;
        while (lq.size() < 9 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        en = 1'b0;
        wait_idle("b2b_idle");
        exp_cnt = exp_cnt + 16'h1;
        checks++;
        if (ur_seen != 1 || underrun_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL b2b_ur: pulses=%0d cnt=%h required 1/%h", ur_seen, underrun_cnt, exp_cnt);
        end
        checks++;
        if (lq.size() != 9) begin
            errors++;
            $display("FAIL b2b_frames: got %0d required 9", lq.size());
        end
        for (int i = 0; i < 9 && lq.size() > 0; i++) begin
            logic [15:0] g;
            logic [15:0] e;
            g = lq.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL b2b_data[%0d]: got %h required %h", i, g, e);
            end
        end
        exp_q.delete();
        lq.delete();
        rq.delete();
    endtask

    task automatic test_en_drop;
        int n = 0;
        int bad = 0;
        push1(16'h8001);
        push1(16'h7FFE);
        en = 1'b1;
        while (ws && n < 600) begin
            @(negedge clk);
            n++;
        end
        repeat (100) @(negedge clk);
        en = 1'b0;
        wait_idle("drop_idle");
        checks++;
        if (lq.size() != 1 || rq.size() != 1) begin
            errors++;
            $display("FAIL drop_frames: got l=%0d r=%0d required 1/1", lq.size(), rq.size());
        end else begin
            checks++;
            if (lq[0] !== 16'h8001 || rq[0] !== 16'h8001) begin
                errors++;
                $display("FAIL drop_data: got l=%h r=%h required 8001", lq[0], rq[0]);
            end
        end
        checks++;
        if ({sck, ws, sd} !== 3'b110 || level !== 4'd1) begin
            errors++;
            $display("FAIL drop_pins: sck/ws/sd=%b level=%0d required 110/1", {sck, ws, sd}, level);
        end
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (!ws || !sck || sd) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL drop_stays_idle: got %0d active clks required 0", bad);
        end
        lq.delete();
        rq.delete();
    endtask

    task automatic test_reset_mid;
        int n = 0;
        en = 1'b1;
        while (ws && n < 600) begin
            @(negedge clk);
            n++;
        end
        push1(16'h1111);
        push1(16'h2222);
        repeat (78) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        checks++;
        if ({sck, ws, sd, s_rdy, underrun} !== 5'b11010) begin
            errors++;
            $display("FAIL rmid_pins: got %b required 11010", {sck, ws, sd, s_rdy, underrun});
        end
        checks++;
        if (level !== 4'd0 || underrun_cnt !== 16'h0) begin
            errors++;
            $display("FAIL rmid_state: level=%0d cnt=%h required 0/0000", level, underrun_cnt);
        end
        en = 1'b0;
        exp_cnt = 16'h0;
        @(negedge clk);
        rstn = 1'b1;
        lq.delete();
        rq.delete();
        @(negedge clk);
    endtask

    task automatic test_saturate;
        en = 1'b1;
        wait_ur("sat_first");
        exp_cnt = exp_cnt + 16'h1;
        @(negedge clk);
        checks++;
        if (underrun_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL sat_first: got %h required %h", underrun_cnt, exp_cnt);
        end
        force dut.underrun_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.underrun_cnt;
        exp_cnt = 16'hFFFE;
        for (int i = 0; i < 2; i++) begin
            wait_ur("sat_wait");
            if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'h1;
            @(negedge clk);
            checks++;
            if (underrun_cnt !== exp_cnt) begin
                errors++;
                $display("FAIL sat_cnt[%0d]: got %h required %h", i, underrun_cnt, exp_cnt);
            end
        end
        en = 1'b0;
        wait_idle("sat_idle");
    endtask

    initial begin
        test_reset();
        test_single();
        test_underrun();
        test_back_to_back();
        test_en_drop();
        test_reset_mid();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
